// File: rtl/clock_controller_if.sv
// Bundles the control inputs and status outputs of the CPU clock-enable sequencer.
// The board/test side uses the master modport. The sequencer uses the slave modport.
interface clock_controller_if #(
   parameter int DIV_W   = 8,
   parameter int BURST_W = 8,
   parameter int CNT_W   = 16
);
   logic               clk_select;
   logic               manual_clk;
   logic               run;
   logic               burst_start;
   logic [BURST_W-1:0] burst_len;
   logic [DIV_W-1:0]   div;
   logic               cpu_ce;
   logic [1:0]         mode;
   logic               busy;
   logic [CNT_W-1:0]   cycle_count;

   modport master (
      output clk_select, manual_clk, run, burst_start, burst_len, div,
      input  cpu_ce, mode, busy, cycle_count
   );

   modport slave (
      input  clk_select, manual_clk, run, burst_start, burst_len, div,
      output cpu_ce, mode, busy, cycle_count
   );
endinterface

// File: rtl/clock_controller.sv
// Decides when the CPU datapath advances by emitting a one-cycle enable.
// The enable comes from halt, divided free-run, debounced manual step, or a counted burst.
module clock_controller #(
   parameter int DIV_W     = 8,
   parameter int BURST_W   = 8,
   parameter int CNT_W     = 16,
   parameter int DB_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   clock_controller_if.slave  bus
);

   localparam int DB_W = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      MANUAL = 2'd2,
      BURST  = 2'd3
   } state_t;

   state_t             state, next_state;
   logic               sel_meta, sel_s, btn_meta, btn_s;
   logic [DB_W-1:0]    db_cnt;
   logic               deb, deb_q, step_pulse;
   logic [DIV_W-1:0]   div_cnt;
   logic               auto_mode, tick;
   logic [BURST_W-1:0] remaining;
   logic               ce_next, cpu_ce;
   logic [CNT_W-1:0]   cycle_count;

   // Switch and button are asynchronous to clk, so each passes two flops before use.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_meta <= 1'b0;
         sel_s    <= 1'b0;
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         sel_meta <= bus.clk_select;
         sel_s    <= sel_meta;
         btn_meta <= bus.manual_clk;
         btn_s    <= btn_meta;
      end
   end

   // The button must differ from the debounced level for DB_CYCLES cycles in a row before it is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt <= '0;
         deb    <= 1'b0;
         deb_q  <= 1'b0;
      end else begin
         deb_q <= deb;
         if (btn_s == deb) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            deb    <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign step_pulse = deb & ~deb_q;

   assign auto_mode = (state == RUN) || (state == BURST);
   assign tick      = auto_mode && (div_cnt >= bus.div);

   // Restarting the divider on state entry makes the first tick land div+1 cycles after entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (!auto_mode || (next_state != state) || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remaining <= '0;
      end else if (state == IDLE && next_state == BURST) begin
         remaining <= bus.burst_len;
      end else if (state == BURST && next_state == MANUAL) begin
         remaining <= '0;
      end else if (state == BURST && tick) begin
         remaining <= remaining - BURST_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (sel_s)
               next_state = MANUAL;
            else if (bus.burst_start && (bus.burst_len != '0))
               next_state = BURST;
            else if (bus.run)
               next_state = RUN;
         end
         RUN: begin
            if (sel_s)
               next_state = MANUAL;
            else if (!bus.run)
               next_state = IDLE;
         end
         MANUAL: begin
            if (!sel_s)
               next_state = IDLE;
         end
         BURST: begin
            if (sel_s)
               next_state = MANUAL;
            else if (tick && (remaining == BURST_W'(1)))
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // The final burst tick still fires as the FSM leaves BURST. Any other state change suppresses the enable.
   always_comb begin
      ce_next = 1'b0;
      case (state)
         RUN:     ce_next = tick && (next_state == RUN);
         BURST:   ce_next = tick && (next_state != MANUAL);
         MANUAL:  ce_next = step_pulse && (next_state == MANUAL);
         default: ce_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_ce      <= 1'b0;
         cycle_count <= '0;
      end else begin
         cpu_ce <= ce_next;
         if (cpu_ce)
            cycle_count <= cycle_count + CNT_W'(1);
      end
   end

   assign bus.cpu_ce      = cpu_ce;
   assign bus.cycle_count = cycle_count;
   assign bus.mode        = state;
   assign bus.busy        = (state == BURST);

endmodule

// File: tb/tb_clock_controller.sv
// Directed self-checking bench for clock_controller.
// It uses a 4-bit cycle counter so that the wrap case can be reached with a short stimulus.
module tb_clock_controller;

   localparam int DIV_W     = 8;
   localparam int BURST_W   = 8;
   localparam int CNT_W     = 4;
   localparam int DB_CYCLES = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checkCount = 0;
   int   passCount  = 0;

   clock_controller_if #(.DIV_W(DIV_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) bus ();

   clock_controller #(
      .DIV_W(DIV_W), .BURST_W(BURST_W), .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic sel, input logic btn, input logic r, input logic bs,
                                input logic [BURST_W-1:0] blen, input logic [DIV_W-1:0] d);
      bus.clk_select  = sel;
      bus.manual_clk  = btn;
      bus.run         = r;
      bus.burst_start = bs;
      bus.burst_len   = blen;
      bus.div         = d;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic countPulses(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.cpu_ce === 1'b1) pulses++;
      end
   endtask

   task automatic resetPulse();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int first;
      int pulses;
      int n;
      logic [7:0]  pat8;
      logic [11:0] pat12;

      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(2);
      checkOutput("reset_cpu_ce", 32'(bus.cpu_ce), 0);
      checkOutput("reset_mode", 32'(bus.mode), 0);
      checkOutput("reset_busy", 32'(bus.busy), 0);
      checkOutput("reset_count", 32'(bus.cycle_count), 0);
      reset = 1'b1;
      countPulses(20, pulses);
      checkOutput("idle_no_ce", 32'(pulses), 0);

      // Free run with div=3. The first enable comes 5 cycles after run rises, then one every 4 cycles.
      applyStimulus(0, 0, 1, 0, 0, 3);
      first = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.cpu_ce === 1'b1) begin
            first = i;
            break;
         end
      end
      checkOutput("run_first_latency", 32'(first), 5);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pat8[i] = bus.cpu_ce;
      end
      checkOutput("run_div3_pattern", 32'(pat8), 32'h88);
      checkOutput("run_mode", 32'(bus.mode), 1);
      checkOutput("run_count", 32'(bus.cycle_count), 2);
      applyStimulus(0, 0, 0, 0, 0, 3);
      @(negedge clk);
      checkOutput("run_drop_mode", 32'(bus.mode), 0);
      checkOutput("run_drop_count", 32'(bus.cycle_count), 3);
      countPulses(20, pulses);
      checkOutput("run_drop_no_ce", 32'(pulses), 0);

      // With div=0 the enable stays high continuously.
      applyStimulus(0, 0, 1, 0, 0, 0);
      waitCycles(2);
      checkOutput("div0_first", 32'(bus.cpu_ce), 1);
      countPulses(10, pulses);
      checkOutput("div0_continuous", 32'(pulses), 10);
      checkOutput("div0_mode", 32'(bus.mode), 1);

      #2 reset = 1'b0;
      #1;
      checkOutput("async_reset_ce", 32'(bus.cpu_ce), 0);
      checkOutput("async_reset_mode", 32'(bus.mode), 0);
      checkOutput("async_reset_count", 32'(bus.cycle_count), 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      countPulses(100, pulses);
      checkOutput("post_reset_no_ce", 32'(pulses), 0);
      checkOutput("post_reset_mode", 32'(bus.mode), 0);

      // The 4-bit counter wraps after 16 enables, so 17 enables leave a count of 1.
      applyStimulus(0, 0, 1, 0, 0, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.cpu_ce === 1'b1) n++;
         if (n == 17) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            break;
         end
      end
      checkOutput("wrap_pulses", 32'(n), 17);
      waitCycles(3);
      checkOutput("wrap_count", 32'(bus.cycle_count), 1);
      checkOutput("wrap_ce_stopped", 32'(bus.cpu_ce), 0);
      checkOutput("wrap_mode", 32'(bus.mode), 0);

      // Manual step: a bouncy press followed by a release gives exactly one enable.
      resetPulse();
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitCycles(5);
      checkOutput("manual_mode", 32'(bus.mode), 2);
      applyStimulus(1, 1, 0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(1, 1, 0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(1, 1, 0, 0, 0, 0);
      first  = 0;
      pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.cpu_ce === 1'b1) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      checkOutput("step_latency", 32'(first), 7);
      checkOutput("step_single_pulse", 32'(pulses), 1);
      applyStimulus(1, 0, 0, 0, 0, 0);
      countPulses(20, pulses);
      checkOutput("step_release_none", 32'(pulses), 0);
      checkOutput("step_count", 32'(bus.cycle_count), 1);

      // A burst of 5 with div=1 gives enables on every second cycle, then returns to IDLE.
      applyStimulus(0, 0, 0, 0, 0, 0);
      resetPulse();
      applyStimulus(0, 0, 0, 1, 5, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 5, 1);
      checkOutput("burst_mode", 32'(bus.mode), 3);
      checkOutput("burst_busy", 32'(bus.busy), 1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         pat12[i] = bus.cpu_ce;
      end
      checkOutput("burst_pattern", 32'(pat12), 32'h2AA);
      checkOutput("burst_done_mode", 32'(bus.mode), 0);
      checkOutput("burst_done_busy", 32'(bus.busy), 0);
      checkOutput("burst_count", 32'(bus.cycle_count), 5);

      applyStimulus(0, 0, 0, 1, 0, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 1);
      waitCycles(2);
      checkOutput("burst_len0_mode", 32'(bus.mode), 0);
      checkOutput("burst_len0_busy", 32'(bus.busy), 0);

      // Switching to manual mid-burst aborts the burst.
      applyStimulus(0, 0, 0, 1, 10, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 10, 1);
      waitCycles(4);
      checkOutput("abort_busy_before", 32'(bus.busy), 1);
      applyStimulus(1, 0, 0, 0, 10, 1);
      waitCycles(3);
      checkOutput("abort_mode", 32'(bus.mode), 2);
      checkOutput("abort_busy", 32'(bus.busy), 0);
      countPulses(20, pulses);
      checkOutput("abort_no_ce", 32'(pulses), 0);

      applyStimulus(0, 0, 0, 0, 0, 2);
      waitCycles(5);
      checkOutput("back_idle_mode", 32'(bus.mode), 0);
      applyStimulus(0, 0, 1, 0, 5, 2);
      waitCycles(2);
      checkOutput("run_again_mode", 32'(bus.mode), 1);
      applyStimulus(0, 0, 1, 1, 5, 2);
      @(negedge clk);
      applyStimulus(0, 0, 1, 0, 5, 2);
      waitCycles(3);
      checkOutput("run_ignore_burst_mode", 32'(bus.mode), 1);
      checkOutput("run_ignore_burst_busy", 32'(bus.busy), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/clock_controller.md
Name: clock_controller

Overview:
Sequencer that decides when the CPU datapath advances. Produces a single-cycle clock enable (cpu_ce) from one of four sources: halted, free-running at a programmable divided rate, manual single-step from a debounced push-button, or a counted burst of N steps. Sits between the board-level clock/button/switch inputs and every enable-qualified register in the core, replacing direct gating of clk.

Parameters:
DIV_W, 8, width of div input
BURST_W, 8, width of burst_len input
CNT_W, 16, width of cycle_count
DB_CYCLES, 4, debounce stable-count (sim default; board builds use 50000)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
clk_select  in  1  async switch: 0 = automatic (halt/run/burst), 1 = manual stepping
manual_clk  in  1  async raw push-button, active-high, bouncy
run  in  1  level: free-run request (automatic mode)
burst_start  in  1  single-cycle pulse: start burst of burst_len steps
burst_len  in  BURST_W  number of enables in a burst
div  in  DIV_W  free-run/burst rate: one enable every div+1 cycles
cpu_ce  out  1  registered one-cycle clock enable to datapath
mode  out  2  current state: 0 IDLE, 1 RUN, 2 MANUAL, 3 BURST
busy  out  1  high while in BURST
cycle_count  out  CNT_W  number of cpu_ce pulses issued, wraps

Behaviour:
- Reset (reset=0): cpu_ce=0, mode=0 (IDLE), busy=0, cycle_count=0; synchronisers, debounce state, divider, burst counter cleared. Reset mid-burst aborts it with no further enables.
- clk_select and manual_clk each pass a 2-flop synchroniser (sel_s, btn_s) before use.
- Debounce: counter counts cycles where btn_s != deb; any cycle with btn_s == deb clears it; when counter == DB_CYCLES-1 and btn_s still differs, deb <= btn_s and counter clears. step_pulse = deb & ~deb_q (rising edge only; release never steps).
- Divider: div_cnt cleared on entry to RUN or BURST and in IDLE/MANUAL; in RUN/BURST tick when div_cnt >= div (then div_cnt <= 0), else div_cnt++. div=0 -> tick every cycle. div lowered below div_cnt -> tick next cycle. First tick occurs div+1 cycles after entering the state.
- State transitions (priority top-down):
  IDLE: sel_s -> MANUAL; burst_start && burst_len!=0 -> BURST (remaining <= burst_len); run -> RUN.
  RUN: sel_s -> MANUAL; !run -> IDLE.
  MANUAL: !sel_s -> IDLE.
  BURST: sel_s -> MANUAL (abort, remaining cleared); on tick with remaining==1 -> IDLE after issuing that enable.
- burst_start ignored outside IDLE; burst_start with burst_len=0 ignored. run changes during BURST ignored; after burst, IDLE re-evaluates run next cycle.
- cpu_ce (registered, next cycle): = tick in RUN/BURST; = step_pulse in MANUAL; 0 in IDLE. Exactly one cycle high per event. step_pulse outside MANUAL discarded (not queued). No enable on the transition cycle itself.
- busy = (mode == BURST). cycle_count += 1 on every cycle cpu_ce is high; wraps 2^CNT_W-1 -> 0.

Test Plan:
- Reset: drive reset=0 mid-RUN with div=0 -> cpu_ce=0, mode=0, cycle_count=0 immediately (async); after release with run=0, no cpu_ce for 100 cycles.
- Free run: clk_select=0, run=1, div=3 -> cpu_ce high 1 cycle in every 4, first pulse 4-5 cycles after run; drop run -> mode=0 and pulses stop; div=0 -> cpu_ce continuously high.
- Manual step with bounce: clk_select=1, toggle manual_clk 0/1 every cycle for 3 cycles then hold 1 for 20 cycles, release -> exactly one cpu_ce pulse, within DB_CYCLES+4 cycles of stable high; cycle_count +1; release gives none.
- Burst: IDLE, burst_len=5, div=1, burst_start pulse -> busy=1, exactly 5 cpu_ce pulses spaced 2 cycles, then mode=0, busy=0, cycle_count=5; burst_len=0 start -> mode stays 0.
- Abort/ignore: during 10-step burst set clk_select=1 -> mode=2 within 3 cycles, busy=0, no more auto pulses; burst_start while RUN -> ignored, remaining RUN.
- Wrap: CNT_W=4, run with div=0 for 17 enables -> cycle_count reads 1.
